// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the 48 MHz UART. It fetches each received byte over a Wishbone master
// port and queues it in a FIFO, which the CPU drains through DATA/STAT slave registers.
module uart_rx_fifo #(
   parameter logic [31:0] DAT_ADR  = 32'h100,
   parameter logic [31:0] STAT_ADR = 32'h101,
   parameter logic [31:0] UART_ADR = 32'h0FF,
   parameter int          AW       = 4,
   parameter logic [4:0]  TIMEOUT  = 5'd16
) (
   input  logic        clk_48_i,
   input  logic        rst_n_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   input  logic        we_i,
   input  logic        stb_i,
   input  logic        cyc_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic [31:0] m_adr_o,
   output logic        m_we_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   input  logic [31:0] m_dat_i,
   input  logic        m_ack_i,
   input  logic        uart_irq_i,
   output logic        irq_o
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      M_IDLE,
      M_REQ,
      M_DONE
   } m_state_t;

   m_state_t      m_state, m_state_nxt;
   logic [4:0]    wait_cnt, wait_cnt_nxt;
   logic          fetch_ok, fetch_tmo;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   count, count_nxt;
   logic          ovf, err;

   logic          sel_dat, sel_stat, cpu_req;
   logic          valid, full;
   logic          push, pop, flush;
   logic          clr_ovf, clr_err, ovf_set;
   logic [7:0]    cnt_wide;
   logic [4:0]    stat_cnt;
   logic          unused_ok;

   assign m_adr_o = UART_ADR;
   assign m_we_o  = 1'b0;

   always_ff @(posedge clk_48_i) begin
      if (!rst_n_i) begin
         m_state  <= M_IDLE;
         wait_cnt <= '0;
      end else begin
         m_state  <= m_state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // M_DONE is a guard cycle: the UART holds ack one cycle longer than needed.
   always_comb begin
      m_state_nxt  = m_state;
      wait_cnt_nxt = wait_cnt;
      fetch_ok     = 1'b0;
      fetch_tmo    = 1'b0;
      m_cyc_o      = 1'b0;
      m_stb_o      = 1'b0;
      case (m_state)
         M_IDLE: begin
            if (uart_irq_i) begin
               m_state_nxt  = M_REQ;
               wait_cnt_nxt = '0;
            end
         end
         M_REQ: begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            if (m_ack_i) begin
               fetch_ok    = 1'b1;
               m_state_nxt = M_DONE;
            end else if (wait_cnt == TIMEOUT - 5'd1) begin
               fetch_tmo   = 1'b1;
               m_state_nxt = M_DONE;
            end else begin
               wait_cnt_nxt = wait_cnt + 5'd1;
            end
         end
         M_DONE: m_state_nxt = M_IDLE;
         default: m_state_nxt = M_IDLE;
      endcase
   end

   assign sel_dat  = (adr_i == DAT_ADR);
   assign sel_stat = (adr_i == STAT_ADR);
   assign cpu_req  = cyc_i & stb_i & (sel_dat | sel_stat);

   assign valid   = (count != '0);
   assign full    = (count == CNT_FULL);
   assign pop     = ack_o & cpu_req & sel_dat & ~we_i & valid;
   assign flush   = ack_o & cpu_req & sel_stat & we_i & dat_i[0];
   assign clr_ovf = ack_o & cpu_req & sel_stat & we_i & dat_i[1];
   assign clr_err = ack_o & cpu_req & sel_stat & we_i & dat_i[2];
   assign push    = fetch_ok & ~full & ~flush;
   assign ovf_set = fetch_ok & full & ~flush;

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (push & ~pop) begin
         count_nxt = count + CNT_ONE;
      end else if (pop & ~push) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // A new ovf/err event in the same cycle as its clear leaves the flag set.
   always_ff @(posedge clk_48_i) begin
      if (!rst_n_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
         ack_o <= 1'b0;
         irq_o <= 1'b0;
      end else begin
         ack_o <= cpu_req & ~ack_o;
         count <= count_nxt;
         irq_o <= (count_nxt != '0);
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
         end
         if (ovf_set)      ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
         if (fetch_tmo)    err <= 1'b1;
         else if (clr_err) err <= 1'b0;
      end
   end

   always_ff @(posedge clk_48_i) begin
      if (rst_n_i && push) mem[tail] <= m_dat_i[7:0];
   end

   assign cnt_wide = 8'(count);
   assign stat_cnt = cnt_wide[4:0];

   // Read data is driven only during the ack cycle; the head byte is masked when empty.
   always_comb begin
      dat_o = '0;
      if (ack_o & cpu_req & ~we_i) begin
         if (sel_dat) begin
            dat_o = valid ? {23'h0, 1'b1, mem[head]} : 32'h0;
         end else begin
            dat_o = {16'h0, 3'b0, stat_cnt, 5'b0, err, ovf, ~valid};
         end
      end
   end

   assign unused_ok = ^{sel_i, dat_i[31:3], m_dat_i[31:8], cnt_wide[7:5]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: the initial block plays both the UART (master-port responder)
// and the CPU, and compares every observation against hand-computed values.
module tb_uart_rx_fifo;

   localparam logic [31:0] DAT  = 32'h100;
   localparam logic [31:0] STAT = 32'h101;

   logic        clk_48 = 1'b0;
   logic        rst_n;
   logic [31:0] adr_s, dat_s, dat_o, m_adr_o, m_dat;
   logic        we_s, stb_s, cyc_s, ack_o, m_we_o, m_cyc_o, m_stb_o, m_ack, uart_irq, irq_o;
   logic [3:0]  sel_s;

   int checks = 0;
   int errors = 0;

   always #5 clk_48 = ~clk_48;

   uart_rx_fifo dut (
      .clk_48_i   (clk_48),
      .rst_n_i    (rst_n),
      .adr_i      (adr_s),
      .dat_i      (dat_s),
      .we_i       (we_s),
      .stb_i      (stb_s),
      .cyc_i      (cyc_s),
      .sel_i      (sel_s),
      .dat_o      (dat_o),
      .ack_o      (ack_o),
      .m_adr_o    (m_adr_o),
      .m_we_o     (m_we_o),
      .m_cyc_o    (m_cyc_o),
      .m_stb_o    (m_stb_o),
      .m_dat_i    (m_dat),
      .m_ack_i    (m_ack),
      .uart_irq_i (uart_irq),
      .irq_o      (irq_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One CPU Wishbone access; strobe is held through the ack cycle, returns at a falling edge.
   task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                                output logic [31:0] rdat, output logic acked);
      acked = 1'b0;
      rdat  = '0;
      @(negedge clk_48);
      cyc_s = 1'b1; stb_s = 1'b1; adr_s = adr; we_s = we; dat_s = wdat;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_48);
         if (ack_o) begin
            acked = 1'b1;
            rdat  = dat_o;
            break;
         end
      end
      if (acked) @(negedge clk_48);
      cyc_s = 1'b0; stb_s = 1'b0; we_s = 1'b0; dat_s = '0; adr_s = '0;
   endtask

   task automatic cpuCheck(input string tag, input logic [31:0] adr, input logic we,
                           input logic [31:0] wdat, input logic [31:0] expected);
      logic [31:0] rdat;
      logic        acked;
      applyStimulus(adr, we, wdat, rdat, acked);
      checkOutput({tag, "_ack"}, 32'(acked), 32'h1);
      if (!we) checkOutput(tag, rdat, expected);
   endtask

   // UART side: raise the interrupt, ack one cycle after strobe, hold ack an extra cycle.
   task automatic uartDeliver(input logic [7:0] b);
      int waited;
      @(negedge clk_48);
      uart_irq = 1'b1;
      m_dat    = {24'hABCDEF, b};
      waited   = 0;
      while (!m_stb_o && waited < 8) begin
         @(negedge clk_48);
         waited++;
      end
      checkOutput("fetch_stb", 32'(m_stb_o), 32'h1);
      @(negedge clk_48);
      m_ack    = 1'b1;
      uart_irq = 1'b0;
      @(negedge clk_48);
      @(negedge clk_48);
      m_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] rdat;
      logic        acked;
      int          waited, stb_cycles, gap;

      rst_n = 1'b0; uart_irq = 1'b1; m_ack = 1'b0; m_dat = 32'h0000_00A5;
      adr_s = '0; dat_s = '0; we_s = 1'b0; stb_s = 1'b0; cyc_s = 1'b0; sel_s = 4'hF;
      repeat (3) @(negedge clk_48);
      checkOutput("rst_ack", 32'(ack_o), 32'h0);
      checkOutput("rst_dat", dat_o, 32'h0);
      checkOutput("rst_cyc", 32'(m_cyc_o), 32'h0);
      checkOutput("rst_stb", 32'(m_stb_o), 32'h0);
      checkOutput("rst_irq", 32'(irq_o), 32'h0);

      // First fetch is started by the interrupt that was already pending during reset.
      rst_n = 1'b1;
      @(negedge clk_48);
      checkOutput("first_stb", 32'(m_stb_o), 32'h1);
      checkOutput("first_cyc", 32'(m_cyc_o), 32'h1);
      checkOutput("m_adr", m_adr_o, 32'h0FF);
      checkOutput("m_we", 32'(m_we_o), 32'h0);
      @(negedge clk_48);
      checkOutput("irq_before_push", 32'(irq_o), 32'h0);
      m_ack = 1'b1; uart_irq = 1'b0;
      @(negedge clk_48);
      checkOutput("irq_after_push", 32'(irq_o), 32'h1);
      checkOutput("stb_after_ack", 32'(m_stb_o), 32'h0);
      @(negedge clk_48);
      m_ack = 1'b0;

      cpuCheck("stat_one", STAT, 1'b0, 32'h0, 32'h0000_0100);
      cpuCheck("data_a5", DAT, 1'b0, 32'h0, 32'h0000_01A5);
      checkOutput("irq_drained", 32'(irq_o), 32'h0);
      cpuCheck("stat_empty", STAT, 1'b0, 32'h0, 32'h0000_0001);

      // Overflow: 17 bytes into a 16-entry FIFO, the last one is lost.
      for (int i = 0; i <= 16; i++) uartDeliver(8'(i));
      cpuCheck("stat_full", STAT, 1'b0, 32'h0, 32'h0000_1002);
      checkOutput("irq_full", 32'(irq_o), 32'h1);
      for (int i = 0; i < 16; i++) cpuCheck("data_order", DAT, 1'b0, 32'h0, 32'h100 | 32'(i));
      cpuCheck("stat_ovf_empty", STAT, 1'b0, 32'h0, 32'h0000_0003);
      cpuCheck("clr_ovf", STAT, 1'b1, 32'h2, 32'h0);
      cpuCheck("stat_ovf_clr", STAT, 1'b0, 32'h0, 32'h0000_0001);
      cpuCheck("data_empty", DAT, 1'b0, 32'h0, 32'h0);
      cpuCheck("stat_after_empty", STAT, 1'b0, 32'h0, 32'h0000_0001);
      cpuCheck("data_write", DAT, 1'b1, 32'hFF, 32'h0);
      cpuCheck("stat_after_dwrite", STAT, 1'b0, 32'h0, 32'h0000_0001);
      applyStimulus(32'h200, 1'b0, 32'h0, rdat, acked);
      checkOutput("bad_adr_noack", 32'(acked), 32'h0);

      // Pop and push land on the same edge while three bytes are queued.
      uartDeliver(8'h31);
      uartDeliver(8'h32);
      uartDeliver(8'h33);
      @(negedge clk_48);
      uart_irq = 1'b1; m_dat = 32'h0000_0034;
      @(negedge clk_48);
      checkOutput("pp_stb", 32'(m_stb_o), 32'h1);
      cyc_s = 1'b1; stb_s = 1'b1; adr_s = DAT; we_s = 1'b0;
      @(negedge clk_48);
      checkOutput("pp_ack", 32'(ack_o), 32'h1);
      checkOutput("pp_dat", dat_o, 32'h0000_0131);
      m_ack = 1'b1; uart_irq = 1'b0;
      @(negedge clk_48);
      cyc_s = 1'b0; stb_s = 1'b0; adr_s = '0;
      @(negedge clk_48);
      m_ack = 1'b0;
      cpuCheck("pp_stat", STAT, 1'b0, 32'h0, 32'h0000_0300);
      cpuCheck("pp_d1", DAT, 1'b0, 32'h0, 32'h0000_0132);
      cpuCheck("pp_d2", DAT, 1'b0, 32'h0, 32'h0000_0133);
      cpuCheck("pp_d3", DAT, 1'b0, 32'h0, 32'h0000_0134);

      // UART never acks: strobe lasts 16 cycles, err is set, fetch retries after the guard cycle.
      @(negedge clk_48);
      uart_irq = 1'b1; m_dat = 32'h0000_0055;
      waited = 0;
      while (!m_stb_o && waited < 8) begin
         @(negedge clk_48);
         waited++;
      end
      stb_cycles = 0;
      while (m_stb_o && stb_cycles < 40) begin
         stb_cycles++;
         @(negedge clk_48);
      end
      checkOutput("timeout_len", 32'(stb_cycles), 32'd16);
      gap = 0;
      while (!m_stb_o && gap < 8) begin
         gap++;
         @(negedge clk_48);
      end
      checkOutput("retry_gap", 32'(gap), 32'd2);
      checkOutput("retry_stb", 32'(m_stb_o), 32'h1);
      @(negedge clk_48);
      m_ack = 1'b1; uart_irq = 1'b0;
      @(negedge clk_48);
      @(negedge clk_48);
      m_ack = 1'b0;
      cpuCheck("stat_err", STAT, 1'b0, 32'h0, 32'h0000_0104);
      cpuCheck("clr_err", STAT, 1'b1, 32'h4, 32'h0);
      cpuCheck("stat_err_clr", STAT, 1'b0, 32'h0, 32'h0000_0100);
      cpuCheck("data_55", DAT, 1'b0, 32'h0, 32'h0000_0155);

      // Flush with five entries queued.
      for (int i = 0; i < 5; i++) uartDeliver(8'h61 + 8'(i));
      cpuCheck("stat_five", STAT, 1'b0, 32'h0, 32'h0000_0500);
      cpuCheck("flush", STAT, 1'b1, 32'h1, 32'h0);
      checkOutput("irq_flush", 32'(irq_o), 32'h0);
      cpuCheck("stat_flushed", STAT, 1'b0, 32'h0, 32'h0000_0001);
      uartDeliver(8'h77);
      cpuCheck("data_after_flush", DAT, 1'b0, 32'h0, 32'h0000_0177);

      // Reset in the middle of a fetch aborts it; the still-pending interrupt restarts it.
      @(negedge clk_48);
      uart_irq = 1'b1; m_dat = 32'h0000_0088;
      waited = 0;
      while (!m_stb_o && waited < 8) begin
         @(negedge clk_48);
         waited++;
      end
      rst_n = 1'b0;
      @(negedge clk_48);
      checkOutput("rst_abort_stb", 32'(m_stb_o), 32'h0);
      checkOutput("rst_abort_cyc", 32'(m_cyc_o), 32'h0);
      rst_n = 1'b1;
      @(negedge clk_48);
      checkOutput("rst_refetch_stb", 32'(m_stb_o), 32'h1);
      @(negedge clk_48);
      m_ack = 1'b1; uart_irq = 1'b0;
      @(negedge clk_48);
      @(negedge clk_48);
      m_ack = 1'b0;
      cpuCheck("data_88", DAT, 1'b0, 32'h0, 32'h0000_0188);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
